// File: rtl/ram_bank.sv
// ram_bank: DEPTH x WIDTH RAM bank with load-gated writes and a registered read port.
// A synchronous reset starts a one-word-per-cycle clear sweep; busy is high while it runs
// and all accesses are ignored during that time.
// Optional feature macro: RAM_BANK_WRITE_FIRST_EN selects write-first behaviour on a
// same-edge write/read collision; the default is read-first.
module ram_bank #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   output logic              busy
);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]    out_q, out_d;
   logic [WIDTH-1:0]    mem [DEPTH];

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [WIDTH-1:0]    wr_data;
   logic                in_range;

   // Only matters for non-power-of-2 depths; otherwise every address is valid.
   assign in_range = (32'(address) < DEPTH);

   // Next-state, single write port selection and read data selection.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_addr = address;
      wr_data = in;
      out_d   = '0;
      unique case (state_q)
         StClear: begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = '0;
            if (ptr_q == LastPtr) begin
               state_d = StIdle;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         StIdle: begin
            wr_en = load && in_range;
            if (in_range) begin
`ifdef RAM_BANK_WRITE_FIRST_EN
               out_d = load ? in : mem[address];
`else
               out_d = mem[address];
`endif
            end
         end
         default: begin
            state_d = StClear;
            ptr_d   = '0;
         end
      endcase
      // A reset edge never writes memory; the sweep starts on the following edge.
      if (reset) begin
         wr_en = 1'b0;
      end
   end

   // State, sweep pointer and read register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StClear;
         ptr_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         out_q   <= out_d;
      end
   end

   // Memory array with one write port and no reset, so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign out  = out_q;
   assign busy = (state_q == StClear);

endmodule
